// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode/funct7 constants, issue-stage state type and instruction field helpers
package riscv_pkg;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  typedef enum logic {EMPTY, HELD} issue_state_e;
  function automatic logic [6:0] opcode(input logic [31:0] i);
    return i[6:0];
  endfunction
  function automatic logic [4:0] rd_idx(input logic [31:0] i);
    return i[11:7];
  endfunction
  function automatic logic [2:0] funct3(input logic [31:0] i);
    return i[14:12];
  endfunction
  function automatic logic [4:0] rs1_idx(input logic [31:0] i);
    return i[19:15];
  endfunction
  function automatic logic [4:0] rs2_idx(input logic [31:0] i);
    return i[24:20];
  endfunction
  function automatic logic [6:0] funct7(input logic [31:0] i);
    return i[31:25];
  endfunction
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction
endpackage

// File: rtl/riscv_issue_stage_if.sv
// riscv_issue_stage_if: valid/ready instruction handoff from the upstream stage into the issue stage
interface riscv_issue_stage_if;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  modport master(output in_valid, output in_instr, input in_ready);
  modport slave(input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/riscv_regfile.sv
// riscv_regfile: REGS x 32 register file, two async read ports, one write port, x0 hardwired to zero
module riscv_regfile #(parameter int REGS = 32) (
  input logic clock,
  input logic reset,
  input logic [4:0] ra1,
  input logic [4:0] ra2,
  input logic [4:0] wa,
  input logic we,
  input logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [REGS];
  function automatic logic live(input logic [4:0] a);
    return a != 5'd0 && 32'(a) < 32'(REGS);
  endfunction
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int r = 0; r < REGS; r++) mem[r] <= '0;
    else if (we && live(wa)) mem[wa] <= wd;
  assign rd1 = live(ra1) ? mem[ra1] : '0;
  assign rd2 = live(ra2) ? mem[ra2] : '0;
endmodule

// File: rtl/riscv_issue_stage.sv
// riscv_issue_stage: RV32IM execute-issue stage; holds one OP/OP-IMM instruction for the ALU, writes back and retires it
module riscv_issue_stage import riscv_pkg::*; #(parameter int REGS = 32) (
  input logic clock,
  input logic reset,
  riscv_issue_stage_if.slave in_if,
  output logic is_op_alu,
  output logic is_op_alu_imm,
  output logic [2:0] op_funct3,
  output logic [6:0] op_funct7,
  output logic [31:0] reg_s1,
  output logic [31:0] reg_s2,
  output logic [31:0] imm,
  input logic [31:0] rd_alu,
  input logic is_alu_wait,
  output logic retire_valid,
  output logic [4:0] retire_rd,
  output logic [31:0] retire_value,
  output logic retire_illegal,
  output logic [31:0] instret,
  output logic [31:0] stall_cycles
);
  issue_state_e state, state_nx;
  logic [31:0] ex_instr, rf_s1, rf_s2;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic ex_valid, legal, active, retire_now, accept, we;
  function automatic logic reg_ok(input logic [4:0] r);
    return 32'(r) < 32'(REGS);
  endfunction
  assign opc = opcode(ex_instr);
  assign f3 = funct3(ex_instr);
  assign f7 = funct7(ex_instr);
  assign legal = opc == OPC_OP ? reg_ok(rd_idx(ex_instr)) && reg_ok(rs1_idx(ex_instr)) && reg_ok(rs2_idx(ex_instr))
                   && (f7 == F7_BASE || f7 == F7_MULDIV || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)))
               : opc == OPC_OP_IMM ? reg_ok(rd_idx(ex_instr)) && reg_ok(rs1_idx(ex_instr))
                   && (f3 == 3'd1 ? f7 == F7_BASE : f3 == 3'd5 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1)
               : 1'b0;
  assign active = ex_valid && legal;
  assign is_op_alu = active && opc == OPC_OP;
  assign is_op_alu_imm = active && opc == OPC_OP_IMM;
  assign op_funct3 = active ? f3 : '0;
  assign op_funct7 = active ? f7 : '0;
  assign reg_s1 = active ? rf_s1 : '0;
  assign reg_s2 = active ? rf_s2 : '0;
  assign imm = active ? imm_i(ex_instr) : '0;
  assign we = retire_now && legal && rd_idx(ex_instr) != 5'd0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nx;
  // Illegal instructions never wait on the ALU; back-to-back accept happens on the retire edge.
  always_comb begin
    ex_valid = state == HELD;
    retire_now = ex_valid && (!legal || !is_alu_wait);
    in_if.in_ready = !ex_valid || retire_now;
    accept = in_if.in_valid && in_if.in_ready;
    state_nx = accept ? HELD : retire_now ? EMPTY : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ex_instr <= '0;
      retire_valid <= 1'b0;
      retire_rd <= '0;
      retire_value <= '0;
      retire_illegal <= 1'b0;
      instret <= '0;
      stall_cycles <= '0;
    end else begin
      if (accept) ex_instr <= in_if.in_instr;
      retire_valid <= retire_now;
      retire_rd <= retire_now ? rd_idx(ex_instr) : '0;
      retire_value <= we ? rd_alu : '0;
      retire_illegal <= retire_now && !legal;
      instret <= instret + 32'(retire_now);
      stall_cycles <= stall_cycles + 32'(ex_valid && is_alu_wait);
    end
  riscv_regfile #(.REGS(REGS)) u_rf (
    .clock(clock),
    .reset(reset),
    .ra1(rs1_idx(ex_instr)),
    .ra2(rs2_idx(ex_instr)),
    .wa(rd_idx(ex_instr)),
    .we(we),
    .wd(rd_alu),
    .rd1(rf_s1),
    .rd2(rf_s2)
  );
endmodule
